miter_cex_monitor: RTL and testbench

- Downstream consumer of the equivalence miter: samples the miter's NotEqv flag and the shared stimulus X every clock.
- Raises a sticky failure flag and records the cycle index of the first mismatch.
- Keeps a rolling trace of the last DEPTH (X, NotEqv) samples, freezes it a fixed number of cycles after the first failure, and streams it out oldest-first on request, for counterexample replay.

---
 rtl/miter_cex_monitor.sv | 186 ++++++++++++++++++
 tb/tb_miter_cex_monitor.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/miter_cex_monitor.sv
// Counterexample monitor for an equivalence miter.
// Samples {X, NotEqv} every clock, flags the first mismatch, keeps a rolling
// trace of the last DEPTH samples, freezes it POST samples after the first
// failure and streams the frozen trace out oldest-first on request.
module miter_cex_monitor #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned POST  = 4,
  parameter int unsigned CW    = 16,
  parameter int unsigned MW    = 8
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          X,
  input  logic          NotEqv,
  output logic          Fail,
  output logic [CW-1:0] FirstFailCycle,
  output logic [CW-1:0] CycleCount,
  output logic [MW-1:0] MismatchCount,
  output logic          Frozen,
  input  logic          RdReq,
  output logic          RdValid,
  output logic [1:0]    RdData,
  output logic          RdDone
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = AW + 1;
  localparam logic [AW-1:0] POST_LAST = AW'((POST == 0) ? 0 : POST - 1);

  typedef enum logic [1:0] {
    S_MONITOR,
    S_POSTFAIL,
    S_FROZEN,
    S_DUMP
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [AW-1:0] post_q, post_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FW-1:0] left_q, left_d;
  logic          fail_q, fail_d;
  logic [CW-1:0] ffc_q, ffc_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [MW-1:0] mm_q, mm_d;
  logic          frozen_q, frozen_d;
  logic          rd_valid_q, rd_valid_d;
  logic [1:0]    rd_data_q, rd_data_d;
  logic          rd_done_q, rd_done_d;

  logic [1:0]    trace_q [DEPTH];
  logic          trace_we;
  logic [AW-1:0] rd_start;

  // Oldest valid entry; when fill==DEPTH the low bits are zero and this is wr_ptr.
  assign rd_start = wr_ptr_q - fill_q[AW-1:0];

  // Next-state and next-output logic for sampling, failure capture and dump.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    fill_d     = fill_q;
    post_d     = post_q;
    rd_ptr_d   = rd_ptr_q;
    left_d     = left_q;
    fail_d     = fail_q;
    ffc_d      = ffc_q;
    cyc_d      = cyc_q;
    mm_d       = mm_q;
    frozen_d   = frozen_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_done_d  = 1'b0;
    trace_we   = 1'b0;

    if (state_q == S_MONITOR || state_q == S_POSTFAIL) begin
      trace_we = 1'b1;
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (fill_q != FW'(DEPTH)) fill_d = fill_q + FW'(1);
      if (cyc_q != '1) cyc_d = cyc_q + CW'(1);
      if (NotEqv && mm_q != '1) mm_d = mm_q + MW'(1);
    end

    case (state_q)
      S_MONITOR: begin
        if (NotEqv) begin
          fail_d = 1'b1;
          ffc_d  = cyc_q;
          post_d = '0;
          if (POST == 0) begin
            state_d  = S_FROZEN;
            frozen_d = 1'b1;
          end else begin
            state_d = S_POSTFAIL;
          end
        end
      end
      S_POSTFAIL: begin
        if (post_q == POST_LAST) begin
          state_d  = S_FROZEN;
          frozen_d = 1'b1;
        end else begin
          post_d = post_q + AW'(1);
        end
      end
      S_FROZEN: begin
        // The first beat is registered on the accepting edge so RdValid
        // appears the cycle after RdReq; a one-entry trace finishes at once.
        if (RdReq) begin
          rd_valid_d = 1'b1;
          rd_data_d  = trace_q[rd_start];
          rd_ptr_d   = rd_start + AW'(1);
          left_d     = fill_q - FW'(1);
          if (fill_q == FW'(1)) rd_done_d = 1'b1;
          else                  state_d   = S_DUMP;
        end
      end
      S_DUMP: begin
        rd_valid_d = 1'b1;
        rd_data_d  = trace_q[rd_ptr_q];
        rd_ptr_d   = rd_ptr_q + AW'(1);
        left_d     = left_q - FW'(1);
        if (left_q == FW'(1)) begin
          rd_done_d = 1'b1;
          state_d   = S_FROZEN;
        end
      end
      default: state_d = S_MONITOR;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_MONITOR;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      post_q     <= '0;
      rd_ptr_q   <= '0;
      left_q     <= '0;
      fail_q     <= 1'b0;
      ffc_q      <= '0;
      cyc_q      <= '0;
      mm_q       <= '0;
      frozen_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      post_q     <= post_d;
      rd_ptr_q   <= rd_ptr_d;
      left_q     <= left_d;
      fail_q     <= fail_d;
      ffc_q      <= ffc_d;
      cyc_q      <= cyc_d;
      mm_q       <= mm_d;
      frozen_q   <= frozen_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_done_q  <= rd_done_d;
    end
  end

  // Trace buffer write of the current {X, NotEqv} sample.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      trace_q <= '{default: '0};
    end else if (trace_we) begin
      trace_q[wr_ptr_q] <= {X, NotEqv};
    end
  end

  assign Fail           = fail_q;
  assign FirstFailCycle = ffc_q;
  assign CycleCount     = cyc_q;
  assign MismatchCount  = mm_q;
  assign Frozen         = frozen_q;
  assign RdValid        = rd_valid_q;
  assign RdData         = rd_data_q;
  assign RdDone         = rd_done_q;

endmodule

// File: tb/tb_miter_cex_monitor.sv
// Self-checking bench for miter_cex_monitor against a sample-history model.
module tb_miter_cex_monitor;

  localparam int DEPTH = 16;
  localparam int POST  = 4;
  localparam int CW    = 16;
  localparam int MW    = 8;

  logic          Clock = 1'b0;
  logic          Reset = 1'b0;
  logic          X = 1'b0;
  logic          NotEqv = 1'b0;
  logic          RdReq = 1'b0;
  logic          Fail;
  logic [CW-1:0] FirstFailCycle;
  logic [CW-1:0] CycleCount;
  logic [MW-1:0] MismatchCount;
  logic          Frozen;
  logic          RdValid;
  logic [1:0]    RdData;
  logic          RdDone;

  miter_cex_monitor #(.DEPTH(DEPTH), .POST(POST), .CW(CW), .MW(MW)) dut (
    .Clock(Clock), .Reset(Reset), .X(X), .NotEqv(NotEqv),
    .Fail(Fail), .FirstFailCycle(FirstFailCycle), .CycleCount(CycleCount),
    .MismatchCount(MismatchCount), .Frozen(Frozen), .RdReq(RdReq),
    .RdValid(RdValid), .RdData(RdData), .RdDone(RdDone)
  );

  always #5 Clock = ~Clock;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: history of recorded samples and pending dump stream.
  bit         m_fail, m_frozen;
  int         m_first, m_cyc, m_mm;
  logic [1:0] m_hist[$];
  logic [1:0] m_stream[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic step(input logic x, input logic ne, input logic rd, input logic rst);
    bit         accept, exp_v, exp_done;
    logic [1:0] exp_d;
    X = x; NotEqv = ne; RdReq = rd; Reset = rst;
    @(posedge Clock);
    exp_v = 0; exp_done = 0; exp_d = '0;
    if (rst) begin
      m_fail = 0; m_frozen = 0; m_first = 0; m_cyc = 0; m_mm = 0;
      m_hist.delete(); m_stream.delete();
    end else begin
      accept = m_frozen && (m_stream.size() == 0) && rd;
      if (!m_frozen) begin
        m_hist.push_back({x, ne});
        if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
        if (ne) begin
          if (m_mm < 2**MW - 1) m_mm++;
          if (!m_fail) begin m_fail = 1; m_first = m_cyc; end
        end
        if (m_cyc < 2**CW - 1) m_cyc++;
        if (m_fail && m_cyc == m_first + POST + 1) m_frozen = 1;
      end
      if (accept) m_stream = m_hist;
      if (m_stream.size() > 0) begin
        exp_v    = 1;
        exp_d    = m_stream.pop_front();
        exp_done = (m_stream.size() == 0);
      end
    end
    #1;
    check("Fail", 32'(Fail), 32'(m_fail));
    check("FirstFailCycle", 32'(FirstFailCycle), 32'(m_fail ? m_first : 0));
    check("CycleCount", 32'(CycleCount), 32'(m_cyc));
    check("MismatchCount", 32'(MismatchCount), 32'(m_mm));
    check("Frozen", 32'(Frozen), 32'(m_frozen));
    check("RdValid", 32'(RdValid), 32'(exp_v));
    check("RdDone", 32'(RdDone), 32'(exp_done));
    if (exp_v || rst) check("RdData", 32'(RdData), 32'(exp_d));
    Reset = 0; RdReq = 0; NotEqv = 0;
  endtask

  initial begin
    int beats;
    logic [1:0] first_stream[$];
    logic [1:0] second_stream[$];

    #1;
    // Clean run with alternating X; RdReq is ignored while monitoring.
    step(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1'(i % 2 == 0), 0, 0, 0);
    check("s1_cyc", 32'(CycleCount), 10);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check("s1_novalid", 32'(RdValid), 0);

    // Single mismatch at index 5, X=1 throughout; two identical dumps.
    step(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step(1, 1'(i == 5), 0, 0);
      if (i == 5) check("s2_ffc", 32'(FirstFailCycle), 5);
      if (i == 8) check("s2_notfrozen", 32'(Frozen), 0);
    end
    check("s2_frozen", 32'(Frozen), 1);
    step(1, 0, 0, 0);
    check("s2_cychold", 32'(CycleCount), 10);
    check("s2_mm", 32'(MismatchCount), 1);
    for (int d = 0; d < 2; d++) begin
      beats = 0;
      step(0, 0, 1, 0);
      for (int i = 0; i < 12; i++) begin
        if (RdValid) begin
          beats++;
          if (d == 0) first_stream.push_back(RdData); else second_stream.push_back(RdData);
          if (beats == 10) check("s2_done", 32'(RdDone), 1);
        end
        step(0, 0, 0, 0);
      end
      check("s2_beats", 32'(beats), 10);
    end
    check("s2_repeat", 32'(first_stream == second_stream), 1);

    // Wrap-around: 30 clean samples, mismatch at index 30.
    step(0, 0, 0, 1);
    for (int i = 0; i < 35; i++) step(1'($urandom), 1'(i == 30), 0, 0);
    check("s3_ffc", 32'(FirstFailCycle), 30);
    beats = 0;
    step(0, 0, 1, 0);
    for (int i = 0; i < 18; i++) begin
      if (RdValid) begin
        beats++;
        if (beats == 12) check("s3_b12", 32'(RdData[0]), 1);
      end
      step(0, 0, 0, 0);
    end
    check("s3_beats", 32'(beats), 16);

    // Mismatches at 3, 4 and 6.
    step(0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      step(1'($urandom), 1'(i == 3 || i == 4 || i == 6), 0, 0);
      if (i == 6) check("s4_notfrozen", 32'(Frozen), 0);
      if (i == 7) check("s4_frozen", 32'(Frozen), 1);
    end
    check("s4_ffc", 32'(FirstFailCycle), 3);
    check("s4_mm", 32'(MismatchCount), 3);

    // Reset during dump beat 3.
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("s5_beat3", 32'(RdValid), 1);
    step(0, 0, 0, 1);
    check("s5_valid_dropped", 32'(RdValid), 0);
    check("s5_nodone", 32'(RdDone), 0);
    step(1, 0, 0, 0);
    check("s5_idx0", 32'(CycleCount), 1);

    // Randomized runs with sparse mismatches, read requests and resets.
    for (int r = 0; r < 25; r++) begin
      step(0, 0, 0, 1);
      for (int i = 0; i < 80; i++)
        step(1'($urandom), 1'($urandom % 24 == 0), 1'($urandom % 6 == 0), 1'($urandom % 300 == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
